// File: rtl/sobel_stream_acc_if.sv
// Streaming bus for sobel_stream_acc: three-row input words in, one result word out.
// The DUT takes the slave modport; the producer/consumer side takes master.
interface sobel_stream_acc_if #(
    parameter int WORD_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] row_a;
    logic [WORD_W-1:0] row_b;
    logic [WORD_W-1:0] row_c;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;

    modport master (
        output in_valid, row_a, row_b, row_c, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, row_a, row_b, row_c, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sobel_stream_acc.sv
// Streaming 3x3 Sobel over packed multi-pixel words, giving saturated magnitude or a thresholded edge map.
// Optional SOBEL_ZERO_BORDER_EN forces every frame-border output pixel to zero.
module sobel_stream_acc #(
    parameter int WIDTH       = 352,
    parameter int HEIGHT      = 288,
    parameter int PX_PER_WORD = 4,
    parameter int PIX_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               mode_i,
    input  logic [PIX_W+2:0]   threshold_i,
    output logic               finish_o,
    sobel_stream_acc_if.slave  bus
);
    localparam int WORD_W    = PX_PER_WORD * PIX_W;
    localparam int ROW_WORDS = WIDTH / PX_PER_WORD;
    localparam int CW        = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
    localparam int RW        = $clog2(HEIGHT);
    localparam int SW        = PIX_W + 2;
    localparam int GW        = PIX_W + 3;
    localparam logic [CW-1:0] LAST_COL = CW'(ROW_WORDS - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);
    localparam logic [GW-1:0] PIX_MAX  = GW'((1 << PIX_W) - 1);

    typedef enum logic [2:0] {IDLE, RUN, FLUSH, DRAIN, DONE} state_t;
    state_t state_q, state_d;

    logic [CW-1:0]    colCnt_q;
    logic [RW-1:0]    rowCnt_q;
    logic             mode_q;
    logic [GW-1:0]    thr_q;
    logic [PIX_W-1:0] curA_q [PX_PER_WORD];
    logic [PIX_W-1:0] curC_q [PX_PER_WORD];
    logic [SW-1:0]    curS_q [PX_PER_WORD];
    logic [PIX_W-1:0] prevA_q, prevC_q;
    logic [SW-1:0]    prevS_q;
    logic [CW-1:0]    curCol_q;
    logic [RW-1:0]    curRow_q;
    logic [GW-1:0]    mag1_q [PX_PER_WORD];
    logic [PX_PER_WORD-1:0] zeroMask1_q, zeroMaskC;
    logic             valid1_q;
    logic             outValid_q;
    logic [WORD_W-1:0] outData_q, outData_d;

    logic [PIX_W-1:0] inA [PX_PER_WORD];
    logic [PIX_W-1:0] inB [PX_PER_WORD];
    logic [PIX_W-1:0] inC [PX_PER_WORD];
    logic [SW-1:0]    inS [PX_PER_WORD];
    logic [PIX_W-1:0] extA [PX_PER_WORD+2];
    logic [PIX_W-1:0] extC [PX_PER_WORD+2];
    logic [SW-1:0]    extS [PX_PER_WORD+2];
    logic [SW-1:0]    tA [PX_PER_WORD];
    logic [SW-1:0]    tC [PX_PER_WORD];
    logic [GW-1:0]    gx [PX_PER_WORD];
    logic [GW-1:0]    gy [PX_PER_WORD];
    logic [GW-1:0]    magC [PX_PER_WORD];
    logic [PIX_W-1:0] pixOut [PX_PER_WORD];

    logic stall, inReady, accept, flushFire, computeFire;

    assign stall       = outValid_q && !bus.out_ready;
    assign inReady     = (state_q == RUN) && !stall;
    assign accept      = bus.in_valid && inReady;
    assign flushFire   = (state_q == FLUSH) && !stall;
    // Word k is finished once word k+1 supplies its right neighbour, or at row end via FLUSH.
    assign computeFire = (accept && (colCnt_q != '0)) || flushFire;

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid_q;
    assign bus.out_data  = outData_q;
    assign finish_o      = (state_q == DONE);

    always_comb begin
        for (int i = 0; i < PX_PER_WORD; i++) begin
            inB[i] = bus.row_b[WORD_W-1-i*PIX_W -: PIX_W];
            inA[i] = (rowCnt_q == '0)     ? inB[i] : bus.row_a[WORD_W-1-i*PIX_W -: PIX_W];
            inC[i] = (rowCnt_q == LAST_ROW) ? inB[i] : bus.row_c[WORD_W-1-i*PIX_W -: PIX_W];
            inS[i] = SW'(inA[i]) + SW'({inB[i], 1'b0}) + SW'(inC[i]);
        end
    end

    // Neighbour strip: [0] is the left pixel, [PX+1] the right pixel, both replicated at the frame edge.
    always_comb begin
        for (int i = 0; i < PX_PER_WORD; i++) begin
            extA[i+1] = curA_q[i];
            extC[i+1] = curC_q[i];
            extS[i+1] = curS_q[i];
        end
        extA[0] = (curCol_q == '0) ? curA_q[0] : prevA_q;
        extC[0] = (curCol_q == '0) ? curC_q[0] : prevC_q;
        extS[0] = (curCol_q == '0) ? curS_q[0] : prevS_q;
        extA[PX_PER_WORD+1] = (state_q == FLUSH) ? curA_q[PX_PER_WORD-1] : inA[0];
        extC[PX_PER_WORD+1] = (state_q == FLUSH) ? curC_q[PX_PER_WORD-1] : inC[0];
        extS[PX_PER_WORD+1] = (state_q == FLUSH) ? curS_q[PX_PER_WORD-1] : inS[0];
        for (int i = 0; i < PX_PER_WORD; i++) begin
            tA[i]   = SW'(extA[i]) + SW'({extA[i+1], 1'b0}) + SW'(extA[i+2]);
            tC[i]   = SW'(extC[i]) + SW'({extC[i+1], 1'b0}) + SW'(extC[i+2]);
            gx[i]   = GW'(extS[i+2]) - GW'(extS[i]);
            gy[i]   = GW'(tA[i]) - GW'(tC[i]);
            magC[i] = (gx[i][GW-1] ? -gx[i] : gx[i]) + (gy[i][GW-1] ? -gy[i] : gy[i]);
        end
    end

    always_comb begin
        zeroMaskC = '0;
`ifdef SOBEL_ZERO_BORDER_EN
        if (curRow_q == '0 || curRow_q == LAST_ROW) zeroMaskC = '1;
        if (curCol_q == '0) zeroMaskC[0] = 1'b1;
        if (curCol_q == LAST_COL) zeroMaskC[PX_PER_WORD-1] = 1'b1;
`endif
    end

    always_comb begin
        outData_d = '0;
        for (int i = 0; i < PX_PER_WORD; i++) begin
            if (mode_q) pixOut[i] = (mag1_q[i] >= thr_q) ? '1 : '0;
            else        pixOut[i] = (mag1_q[i] > PIX_MAX) ? '1 : mag1_q[i][PIX_W-1:0];
            if (zeroMask1_q[i]) pixOut[i] = '0;
            outData_d[WORD_W-1-i*PIX_W -: PIX_W] = pixOut[i];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (accept && colCnt_q == LAST_COL) state_d = FLUSH;
            FLUSH:   if (!stall) state_d = (curRow_q == LAST_ROW) ? DRAIN : RUN;
            DRAIN:   if (!valid1_q && (!outValid_q || bus.out_ready)) state_d = DONE;
            DONE:    if (!start_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            colCnt_q <= '0;
            rowCnt_q <= '0;
            mode_q   <= 1'b0;
            thr_q    <= '0;
        end else if (state_q == IDLE && start_i) begin
            colCnt_q <= '0;
            rowCnt_q <= '0;
            mode_q   <= mode_i;
            thr_q    <= threshold_i;
        end else if (accept) begin
            if (colCnt_q == LAST_COL) begin
                colCnt_q <= '0;
                rowCnt_q <= (rowCnt_q == LAST_ROW) ? '0 : rowCnt_q + RW'(1);
            end else begin
                colCnt_q <= colCnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PX_PER_WORD; i++) begin
                curA_q[i] <= '0;
                curC_q[i] <= '0;
                curS_q[i] <= '0;
            end
            prevA_q  <= '0;
            prevC_q  <= '0;
            prevS_q  <= '0;
            curCol_q <= '0;
            curRow_q <= '0;
        end else if (accept) begin
            prevA_q <= curA_q[PX_PER_WORD-1];
            prevC_q <= curC_q[PX_PER_WORD-1];
            prevS_q <= curS_q[PX_PER_WORD-1];
            for (int i = 0; i < PX_PER_WORD; i++) begin
                curA_q[i] <= inA[i];
                curC_q[i] <= inC[i];
                curS_q[i] <= inS[i];
            end
            curCol_q <= colCnt_q;
            curRow_q <= rowCnt_q;
        end
    end

    // Both pipeline stages advance together and freeze as a unit on backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PX_PER_WORD; i++) mag1_q[i] <= '0;
            zeroMask1_q <= '0;
            valid1_q    <= 1'b0;
            outValid_q  <= 1'b0;
            outData_q   <= '0;
        end else if (!stall) begin
            for (int i = 0; i < PX_PER_WORD; i++) mag1_q[i] <= magC[i];
            zeroMask1_q <= zeroMaskC;
            valid1_q    <= computeFire;
            outValid_q  <= valid1_q;
            outData_q   <= outData_d;
        end
    end
endmodule

// File: tb/tb_sobel_stream_acc.sv
// Self-checking bench for sobel_stream_acc on an 8x3 frame with 4 pixels per word.
// Expected words come from a clamped-index Sobel model over the whole frame image.
module tb_sobel_stream_acc;
    localparam int WIDTH     = 8;
    localparam int HEIGHT    = 3;
    localparam int PX        = 4;
    localparam int PIX_W     = 8;
    localparam int WORD_W    = 32;
    localparam int ROW_WORDS = WIDTH / PX;
    localparam int NWORDS    = HEIGHT * ROW_WORDS;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [10:0] threshold;
    logic        finish;

    sobel_stream_acc_if #(.WORD_W(WORD_W)) bus ();

    sobel_stream_acc #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .PX_PER_WORD(PX), .PIX_W(PIX_W)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start), .mode_i(mode),
        .threshold_i(threshold), .finish_o(finish), .bus(bus)
    );

    always #5 clk = ~clk;

    int testsRun = 0;
    int testsFailed = 0;
    int img [HEIGHT][WIDTH];
    logic [31:0] expWords [$];
    logic [31:0] gotWords [$];

    function automatic int pix(int y, int x);
        int yy, xx;
        yy = (y < 0) ? 0 : ((y >= HEIGHT) ? HEIGHT - 1 : y);
        xx = (x < 0) ? 0 : ((x >= WIDTH) ? WIDTH - 1 : x);
        return img[yy][xx];
    endfunction

    function automatic void buildExpected(bit m, int thr);
        int x, sL, sR, tA, tC, gx, gy, mag, pv;
        logic [31:0] w;
        expWords.delete();
        for (int y = 0; y < HEIGHT; y++) begin
            for (int k = 0; k < ROW_WORDS; k++) begin
                w = '0;
                for (int i = 0; i < PX; i++) begin
                    x   = k * PX + i;
                    sL  = pix(y-1, x-1) + 2*pix(y, x-1) + pix(y+1, x-1);
                    sR  = pix(y-1, x+1) + 2*pix(y, x+1) + pix(y+1, x+1);
                    tA  = pix(y-1, x-1) + 2*pix(y-1, x) + pix(y-1, x+1);
                    tC  = pix(y+1, x-1) + 2*pix(y+1, x) + pix(y+1, x+1);
                    gx  = sR - sL;
                    gy  = tA - tC;
                    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                    if (m) pv = (mag >= thr) ? 255 : 0;
                    else   pv = (mag > 255) ? 255 : mag;
`ifdef SOBEL_ZERO_BORDER_EN
                    if (y == 0 || y == HEIGHT-1 || x == 0 || x == WIDTH-1) pv = 0;
`endif
                    w[31-8*i -: 8] = 8'(pv);
                end
                expWords.push_back(w);
            end
        end
    endfunction

    function automatic logic [31:0] rowWord(int r, int k);
        logic [31:0] w;
        if (r < 0 || r >= HEIGHT) return $urandom();
        w = '0;
        for (int i = 0; i < PX; i++) w[31-8*i -: 8] = 8'(img[r][k*PX+i]);
        return w;
    endfunction

    task automatic applyStimulus(input int gapPct, input bit checkFlush);
        bit accepted;
        bit pendingFlush = 0;
        bit pendingLat = 0;
        for (int r = 0; r < HEIGHT; r++) begin
            for (int k = 0; k < ROW_WORDS; k++) begin
                for (int g = 0; g < 3 && $urandom_range(99) < gapPct; g++) begin
                    bus.in_valid = 1'b0;
                    bus.row_a = $urandom(); bus.row_b = $urandom(); bus.row_c = $urandom();
                    @(posedge clk); #1;
                end
                bus.in_valid = 1'b1;
                bus.row_a = rowWord(r-1, k);
                bus.row_b = rowWord(r, k);
                bus.row_c = rowWord(r+1, k);
                accepted = 0;
                for (int w = 0; w < 500 && !accepted; w++) begin
                    @(negedge clk);
                    if (pendingFlush) begin
                        pendingFlush = 0;
                        testsRun++;
                        if (bus.in_ready !== 1'b1) begin
                            testsFailed++;
                            $display("[TB] FAIL flush_release row %0d: in_ready=%b required 1", r, bus.in_ready);
                        end
                        if (pendingLat) begin
                            pendingLat = 0;
                            testsRun++;
                            if (bus.out_valid !== 1'b1) begin
                                testsFailed++;
                                $display("[TB] FAIL latency_rise: out_valid=%b required 1", bus.out_valid);
                            end
                        end
                    end
                    if (bus.in_ready === 1'b1) accepted = 1;
                    @(posedge clk); #1;
                end
                if (!accepted) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL accept_timeout row %0d word %0d: in_ready=0 required 1", r, k);
                    bus.in_valid = 1'b0;
                    return;
                end
                if (checkFlush && k == ROW_WORDS-1) begin
                    @(negedge clk);
                    testsRun++;
                    if (bus.in_ready !== 1'b0) begin
                        testsFailed++;
                        $display("[TB] FAIL flush_gap row %0d: in_ready=%b required 0", r, bus.in_ready);
                    end
                    if (r == 0) begin
                        testsRun++;
                        if (bus.out_valid !== 1'b0) begin
                            testsFailed++;
                            $display("[TB] FAIL latency_early: out_valid=%b required 0", bus.out_valid);
                        end
                    end
                    @(posedge clk); #1;
                    pendingFlush = (r < HEIGHT-1);
                    pendingLat   = (r == 0);
                end
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic collectOutput(input int readyPct, input int holdAt);
        int received = 0;
        int holdLeft = 0;
        int cycles = 0;
        bit pend = 0;
        logic [31:0] held = '0;
        gotWords.delete();
        while (received < NWORDS && cycles < 3000) begin
            if (holdLeft > 0) begin
                bus.out_ready = 1'b0;
                holdLeft--;
            end else begin
                bus.out_ready = ($urandom_range(99) < readyPct);
            end
            @(negedge clk);
            if (pend) begin
                testsRun++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== held) begin
                    testsFailed++;
                    $display("[TB] FAIL hold_stable: valid=%b data=%h required 1 %h", bus.out_valid, bus.out_data, held);
                end
            end
            pend = 0;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b0) begin
                pend = 1;
                held = bus.out_data;
                testsRun++;
                if (bus.in_ready !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL stall_in_ready: in_ready=%b required 0", bus.in_ready);
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                testsRun++;
                if (finish !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL finish_early word %0d: finish=%b required 0", received, finish);
                end
                testsRun++;
                if (bus.out_data !== expWords[received]) begin
                    testsFailed++;
                    $display("[TB] FAIL word %0d: got %h required %h", received, bus.out_data, expWords[received]);
                end
                gotWords.push_back(bus.out_data);
                received++;
                if (received == holdAt) holdLeft = 10;
            end
            @(posedge clk); #1;
            cycles++;
        end
        bus.out_ready = 1'b1;
        if (received < NWORDS) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL output_timeout: got %0d words required %0d", received, NWORDS);
        end
    endtask

    task automatic run_frame(input bit m, input int thr, input int gapPct, input int readyPct,
                             input int holdAt, input bit checkFlush, input bit holdStart);
        bit seen = 0;
        bit extra = 0;
        buildExpected(m, thr);
        mode = m;
        threshold = 11'(thr);
        start = 1'b1;
        @(posedge clk); #1;
        if (!holdStart) start = 1'b0;
        mode = 1'($urandom());
        threshold = 11'($urandom());
        fork
            applyStimulus(gapPct, checkFlush);
            collectOutput(readyPct, holdAt);
        join
        for (int w = 0; w < 8 && !seen; w++) begin
            @(negedge clk);
            if (finish === 1'b1) seen = 1;
            else if (bus.out_valid === 1'b1) extra = 1;
            @(posedge clk); #1;
        end
        testsRun++;
        if (!seen) begin
            testsFailed++;
            $display("[TB] FAIL finish_timeout: finish=0 required 1");
        end
        testsRun++;
        if (extra) begin
            testsFailed++;
            $display("[TB] FAIL extra_output: out_valid=1 required 0 after last word");
        end
        if (holdStart) begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            testsRun++;
            if (finish !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL done_hold: finish=%b required 1", finish);
            end
            @(posedge clk); #1;
            start = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            testsRun++;
            if (finish !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL done_release: finish=%b required 0", finish);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b1;
        bus.row_a = $urandom(); bus.row_b = $urandom(); bus.row_c = $urandom();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        testsRun += 4;
        if (bus.in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_in_ready: %b required 0", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_valid: %b required 0", bus.out_valid); end
        if (bus.out_data !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_out_data: %h required 0", bus.out_data); end
        if (finish !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_finish: %b required 0", finish); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_uniform();
        for (int y = 0; y < HEIGHT; y++)
            for (int x = 0; x < WIDTH; x++) img[y][x] = 8'h40;
        run_frame(1'b0, 0, 0, 100, 0, 1'b0, 1'b1);
        testsRun++;
        if (gotWords.size() != NWORDS) begin
            testsFailed++;
            $display("[TB] FAIL uniform_count: got %0d required %0d", gotWords.size(), NWORDS);
        end
        foreach (gotWords[i]) begin
            testsRun++;
            if (gotWords[i] !== 32'h0) begin
                testsFailed++;
                $display("[TB] FAIL uniform_word %0d: got %h required 00000000", i, gotWords[i]);
            end
        end
    endtask

    task automatic test_step();
        logic [31:0] want;
        for (int y = 0; y < HEIGHT; y++)
            for (int x = 0; x < WIDTH; x++) img[y][x] = (x < 4) ? 0 : 255;
        run_frame(1'b0, 0, 30, 70, 0, 1'b0, 1'b0);
        foreach (gotWords[i]) begin
            want = (i % 2 == 0) ? 32'h000000FF : 32'hFF000000;
`ifdef SOBEL_ZERO_BORDER_EN
            if (i / 2 != 1) want = 32'h0;
`endif
            testsRun++;
            if (gotWords[i] !== want) begin
                testsFailed++;
                $display("[TB] FAIL step_word %0d: got %h required %h", i, gotWords[i], want);
            end
        end
    endtask

    task automatic test_ramp_threshold();
        logic [31:0] want;
        for (int y = 0; y < HEIGHT; y++)
            for (int x = 0; x < WIDTH; x++) img[y][x] = 10 * x;
        run_frame(1'b1, 80, 20, 80, 0, 1'b0, 1'b0);
        foreach (gotWords[i]) begin
            want = (i % 2 == 0) ? 32'h00FFFFFF : 32'hFFFFFF00;
`ifdef SOBEL_ZERO_BORDER_EN
            if (i / 2 != 1) want = 32'h0;
`endif
            testsRun++;
            if (gotWords[i] !== want) begin
                testsFailed++;
                $display("[TB] FAIL ramp80_word %0d: got %h required %h", i, gotWords[i], want);
            end
        end
        run_frame(1'b1, 81, 20, 80, 0, 1'b0, 1'b0);
        foreach (gotWords[i]) begin
            testsRun++;
            if (gotWords[i] !== 32'h0) begin
                testsFailed++;
                $display("[TB] FAIL ramp81_word %0d: got %h required 00000000", i, gotWords[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        for (int y = 0; y < HEIGHT; y++)
            for (int x = 0; x < WIDTH; x++) img[y][x] = $urandom_range(255);
        run_frame(1'b0, 0, 0, 100, 2, 1'b0, 1'b0);
        testsRun++;
        if (gotWords.size() != NWORDS) begin
            testsFailed++;
            $display("[TB] FAIL backpressure_count: got %0d required %0d", gotWords.size(), NWORDS);
        end
    endtask

    task automatic test_back_to_back();
        for (int y = 0; y < HEIGHT; y++)
            for (int x = 0; x < WIDTH; x++) img[y][x] = $urandom_range(255);
        run_frame(1'b1, $urandom_range(100, 500), 0, 100, 0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_midframe();
        bit accepted;
        for (int y = 0; y < HEIGHT; y++)
            for (int x = 0; x < WIDTH; x++) img[y][x] = $urandom_range(255);
        mode = 1'b0;
        start = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 3; n++) begin
            bus.in_valid = 1'b1;
            bus.row_a = rowWord(n/2 - 1, n%2);
            bus.row_b = rowWord(n/2, n%2);
            bus.row_c = rowWord(n/2 + 1, n%2);
            accepted = 0;
            for (int w = 0; w < 50 && !accepted; w++) begin
                @(negedge clk);
                if (bus.in_ready === 1'b1) accepted = 1;
                @(posedge clk); #1;
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        testsRun += 3;
        if (bus.out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_out_valid: %b required 0", bus.out_valid); end
        if (bus.in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_in_ready: %b required 0", bus.in_ready); end
        if (finish !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_finish: %b required 0", finish); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        run_frame(1'($urandom()), $urandom_range(0, 600), 30, 60, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            for (int y = 0; y < HEIGHT; y++)
                for (int x = 0; x < WIDTH; x++) img[y][x] = $urandom_range(255);
            run_frame(1'($urandom()), $urandom_range(0, 600), 40, 60, 0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        mode = 1'b0;
        threshold = '0;
        bus.in_valid = 1'b0;
        bus.row_a = '0;
        bus.row_b = '0;
        bus.row_c = '0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_uniform();
        test_step();
        test_ramp_threshold();
        test_backpressure();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/sobel_stream_acc.md
Name: sobel_stream_acc

Overview:
Parametrised successor to the task-3 edge-detection accelerator. It computes a 3x3 Sobel gradient over a WIDTH x HEIGHT frame that arrives as packed multi-pixel words from three rows at once (above, centre, below). Pixel width, pixels per word and frame size are generic. Input and output use valid/ready handshakes with full backpressure, replacing the fixed-wait en/we sequencing. Output is either saturated gradient magnitude or a binary thresholded edge map.

Parameters:
WIDTH, 352, frame width in pixels; must be a multiple of PX_PER_WORD.
HEIGHT, 288, frame height in rows; must be at least 2.
PX_PER_WORD, 4, pixels packed per word; must be at least 2.
PIX_W, 8, bits per pixel.
Derived: WORD_W = PX_PER_WORD*PIX_W; ROW_WORDS = WIDTH/PX_PER_WORD.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  frame request; level-sensitive, sampled only in IDLE
mode  in  1  0 = magnitude, 1 = threshold; latched on start
threshold  in  PIX_W+3  threshold compare value; latched on start
finish  out  1  high while in DONE
in_valid  in  1  the three row words are valid
in_ready  out  1  the block accepts a word this cycle
row_a  in  WORD_W  word from row r-1
row_b  in  WORD_W  word from row r
row_c  in  WORD_W  word from row r+1
out_valid  out  WORD_W-independent 1  result word valid
out_ready  in  1  the consumer accepts the result word
out_data  out  WORD_W  result word; pixel 0 (leftmost) occupies the MSBs

Behaviour:
- Reset, and every rst assertion including mid-frame: state=IDLE; in_ready=0, out_valid=0, out_data=0, finish=0. Counters, window registers and the pipeline are cleared. There is no partial-frame output after reset.
- States:
  - IDLE: start=1 -> RUN.
  - RUN: accepts words. On acceptance of the last word of a row -> FLUSH.
  - FLUSH: one cycle in which in_ready=0. Emits the final word of the row using right-edge replication. Next state is RUN, or DRAIN after the last row.
  - DRAIN: waits until the pipeline is empty and the last output handshake completes -> DONE.
  - DONE: finish=1. start=0 -> IDLE.
- Accept: occurs when in_valid && in_ready. in_ready = (state==RUN) && !stall. stall = out_valid && !out_ready.
- Pipeline: every stage freezes while stall is high. out_data holds stable while out_valid && !out_ready.
- Counters: row and column word counters advance only on accept. The column counter wraps at ROW_WORDS-1, then the row counter increments.
- Word k of a row becomes computable on the accept of word k+1, or on the FLUSH cycle for k=ROW_WORDS-1. Without stalls, out_valid for word k rises exactly 2 cycles after that event.
- Output count: exactly HEIGHT*ROW_WORDS words in raster order, none dropped and none duplicated.
- Borders use replication:
  - Row 0: row_a is ignored and row_b is used in its place.
  - Row HEIGHT-1: row_c is ignored and row_b is used in its place.
  - Pixel x=0 uses x-1 := x. Pixel x=WIDTH-1 uses x+1 := x.
- Arithmetic, per pixel:
  - Column sums: s(col) = a+2b+c. Row sums: t(row) = p[x-1]+2p[x]+p[x+1]. Both are PIX_W+2 bits.
  - gx = s(x+1)-s(x-1); gy = t(a)-t(c). Both are signed, PIX_W+3 bits.
  - mag = |gx|+|gy|, unsigned, PIX_W+3 bits, computed without overflow.
  - mode 0: pixel = min(mag, 2^PIX_W-1).
  - mode 1: pixel = all-ones if mag >= threshold, else 0. The compare uses the unsaturated mag.
- mode and threshold changes are ignored outside IDLE.
- start held high through DONE keeps the block in DONE; no new frame starts until start returns low.
- in_valid during IDLE, FLUSH, DRAIN or DONE is ignored.

Optional Feature:
SOBEL_ZERO_BORDER_EN
- Defined: every output pixel in row 0, row HEIGHT-1, column 0 or column WIDTH-1 is forced to 0 in both modes. Latency and handshakes are unchanged.
- Undefined: border pixels are computed with replication as described above.

Test Plan:
- WIDTH=8, HEIGHT=3, all pixels 0x40, mode 0 -> 6 output words, all 0x00000000. finish rises after the 6th output handshake.
- Same size; columns 0-3 = 0x00, columns 4-7 = 0xFF; mode 0 -> every row outputs 0x000000FF, 0xFF000000. With SOBEL_ZERO_BORDER_EN, rows 0 and 2 output 0, and row 1 outputs 0x000000FF, 0xFF000000.
- Horizontal ramp p[x]=10x, mode 1:
  - threshold=80 -> pixels 1-6 = 0xFF, pixels 0 and 7 = 0x00 (gx=40 at the edges).
  - threshold=81 -> all 0x00.
- out_ready held low for 10 cycles mid-row -> out_data stable, in_ready=0 throughout. On release, the remaining words arrive in order with the total still 6.
- Every row end -> in_ready=0 for exactly 1 cycle (FLUSH) after the accept of word ROW_WORDS-1, with in_valid held high.
- rst asserted for 1 cycle mid-row 1 -> next cycle out_valid=0, in_ready=0, finish=0. A restarted frame produces correct, complete output.
